jk_excitation_driver: RTL and testbench

- Initiator side of the JK flip-flop interface: turns a target Q sequence into per-cycle J/K excitation (ports a = J, b = K) to drive an external JK flop.
- Keeps an internal JK model of the flop and, optionally, compares the flop's fed-back Q against the model.
- Used as a sequence generator and self-checking driver for JK flop blocks and benches in the design.

---
 rtl/jk_excitation_driver.sv | 164 ++++++++++++++++
 tb/tb_jk_excitation_driver.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excitation_driver.sv
// JK flop excitation driver: turns a target Q sequence (LSB first) into registered J/K drive
// and tracks the driven flop with an internal JK model. Optional self-check: JKDRV_SELF_CHECK_EN.
module jk_excitation_driver #(
    parameter int SEQ_W     = 8,
    parameter int DC_POLICY = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SEQ_W-1:0] seq_in,
    input  logic             q_fb,
    output logic             a,
    output logic             b,
    output logic             exp_q,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [7:0]       err_count
);

    localparam int IDX_W = $clog2(SEQ_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [SEQ_W-1:0] seq_sh, seq_sh_nxt;
    logic [1:0]       ab_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             clr_chk;
    logic             nxt;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic r;
        case ({j, k})
            2'b00:   r = q;
            2'b01:   r = 1'b0;
            2'b10:   r = 1'b1;
            default: r = ~q;
        endcase
        return r;
    endfunction

    // Don't-care resolution: DC_POLICY 1 drives both inputs on a state change (toggle).
    function automatic logic [1:0] excite(input logic c, input logic t);
        logic [1:0] r;
        if (c == t)
            r = 2'b00;
        else if (DC_POLICY == 1)
            r = 2'b11;
        else if (t)
            r = 2'b10;
        else
            r = 2'b01;
        return r;
    endfunction

    assign nxt = jk_next(exp_q, a, b);

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        seq_sh_nxt = seq_sh;
        ab_nxt     = 2'b00;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        clr_chk    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    seq_sh_nxt = seq_in;
                    clr_chk    = 1'b1;
                    busy_nxt   = 1'b1;
                    ab_nxt     = 2'b01;
                    idx_nxt    = '0;
                    state_nxt  = CLEAR;
                end
            end
            CLEAR: begin
                ab_nxt     = excite(1'b0, seq_sh[0]);
                seq_sh_nxt = seq_sh >> 1;
                idx_nxt    = IDX_W'(1);
                state_nxt  = RUN;
            end
            RUN: begin
                if (idx == IDX_W'(SEQ_W)) begin
                    state_nxt = DRAIN;
                end else begin
                    ab_nxt     = excite(nxt, seq_sh[0]);
                    seq_sh_nxt = seq_sh >> 1;
                    idx_nxt    = idx + IDX_W'(1);
                end
            end
            DRAIN: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                idx_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            a     <= 1'b0;
            b     <= 1'b0;
            exp_q <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            a     <= ab_nxt[1];
            b     <= ab_nxt[0];
            exp_q <= nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Sequence shift register is pure data and is always reloaded at start.
    always_ff @(posedge clk) begin
        seq_sh <= seq_sh_nxt;
    end

`ifdef JKDRV_SELF_CHECK_EN
    logic chk_win;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign chk_win = (state == RUN) || (state == DRAIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            mismatch  <= 1'b0;
            err_count <= 8'd0;
        end else if (clr_chk) begin
            mismatch  <= 1'b0;
            err_count <= 8'd0;
        end else if (chk_win && (q_fb != exp_q)) begin
            mismatch  <= 1'b1;
            err_count <= sat_inc(err_count);
        end
    end
`else
    logic unused_chk;

    assign unused_chk = q_fb ^ clr_chk;
    assign mismatch   = 1'b0;
    assign err_count  = 8'd0;
`endif

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: two instances (DC_POLICY 0 and 1) each driving a JK flop model,
// with a scoreboard of per-run expectations checked when each done pulse appears.
module tb_jk_excitation_driver;

`ifdef JKDRV_SELF_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] ab;
        logic [7:0]  q;
        logic [7:0]  err;
        logic        mm;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] seq_in;
    logic       force0;
    logic [1:0] a_v, b_v, expq_v, busy_v, done_v, mm_v, q_fb_v;
    logic [1:0] flop_q;
    logic [7:0] err0, err1;

    int errors = 0;
    int checks = 0;

    exp_t sbq0[$];
    exp_t sbq1[$];

    always #5 clk = ~clk;

    jk_excitation_driver #(.SEQ_W(8), .DC_POLICY(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .seq_in(seq_in), .q_fb(q_fb_v[0]),
        .a(a_v[0]), .b(b_v[0]), .exp_q(expq_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .mismatch(mm_v[0]), .err_count(err0)
    );

    jk_excitation_driver #(.SEQ_W(8), .DC_POLICY(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .seq_in(seq_in), .q_fb(q_fb_v[1]),
        .a(a_v[1]), .b(b_v[1]), .exp_q(expq_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .mismatch(mm_v[1]), .err_count(err1)
    );

    // External JK flops driven by each instance.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset)
                flop_q[i] <= 1'b0;
            else
                case ({a_v[i], b_v[i]})
                    2'b00:   flop_q[i] <= flop_q[i];
                    2'b01:   flop_q[i] <= 1'b0;
                    2'b10:   flop_q[i] <= 1'b1;
                    default: flop_q[i] <= ~flop_q[i];
                endcase
        end
    end

    assign q_fb_v = force0 ? 2'b00 : flop_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: builds per-run traces, pops the scoreboard on every done pulse.
    int         cnt[2];
    logic       busy_prev[2];
    logic [15:0] ab_tr[2];
    logic [7:0] q_tr[2];
    logic [7:0] e_tr[2];
    exp_t       e;
    logic [7:0] ec;

    initial begin
        for (int i = 0; i < 2; i++) begin
            cnt[i]       = 0;
            busy_prev[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (busy_v[i] === 1'b1 && busy_prev[i] !== 1'b1)
                cnt[i] = 0;
            else
                cnt[i] = cnt[i] + 1;
            busy_prev[i] = busy_v[i];
            if (cnt[i] >= 1 && cnt[i] <= 8)
                ab_tr[i][4'(2 * (8 - cnt[i])) +: 2] = {a_v[i], b_v[i]};
            if (cnt[i] >= 2 && cnt[i] <= 9) begin
                q_tr[i][3'(cnt[i] - 2)] = flop_q[i];
                e_tr[i][3'(cnt[i] - 2)] = expq_v[i];
            end
            if (done_v[i] === 1'b1) begin
                ec = (i == 0) ? err0 : err1;
                if ((i == 0 && sbq0.size() == 0) || (i == 1 && sbq1.size() == 0)) begin
                    chk($sformatf("unexpected_done%0d", i), 32'd1, 32'd0);
                end else begin
                    e = (i == 0) ? sbq0.pop_front() : sbq1.pop_front();
                    chk($sformatf("latency%0d", i), 32'(cnt[i]), 32'd10);
                    chk($sformatf("ab_trace%0d", i), 32'(ab_tr[i]), 32'(e.ab));
                    chk($sformatf("flop_q_trace%0d", i), 32'(q_tr[i]), 32'(e.q));
                    chk($sformatf("exp_q_trace%0d", i), 32'(e_tr[i]), 32'(e.q));
                    chk($sformatf("err_count%0d", i), 32'(ec), 32'(e.err));
                    chk($sformatf("mismatch%0d", i), 32'(mm_v[i]), 32'(e.mm));
                end
            end
        end
    end

    task automatic push(input logic [7:0] s, input logic [15:0] ab0, input logic [15:0] ab1,
                        input logic f);
        exp_t x;
        x.q   = s;
        x.err = (CHK && f) ? 8'd8 : 8'd0;
        x.mm  = CHK && f;
        x.ab  = ab0;
        sbq0.push_back(x);
        x.ab  = ab1;
        sbq1.push_back(x);
    endtask

    task automatic run(input logic [7:0] s, input logic [15:0] ab0, input logic [15:0] ab1,
                       input logic f);
        push(s, ab0, ab1, f);
        seq_in = s;
        force0 = f;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        seq_in = ~s;
        repeat (12) @(posedge clk);
        #1;
        force0 = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ab"},    32'({a_v, b_v}), 32'd0);
        chk({tag, "_exp_q"}, 32'(expq_v), 32'd0);
        chk({tag, "_busy"},  32'(busy_v), 32'd0);
        chk({tag, "_done"},  32'(done_v), 32'd0);
        chk({tag, "_mm"},    32'(mm_v), 32'd0);
        chk({tag, "_err"},   32'({err0, err1}), 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        seq_in = 8'h00;
        force0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Mixed pattern; seq_in scrambled after the start edge.
        run(8'hB2, 16'b00_10_01_00_10_00_01_10, 16'b00_11_11_00_11_00_11_11, 1'b0);
        // Alternating pattern: toggle encoding drives 11 every step.
        run(8'h55, 16'b10_01_10_01_10_01_10_01, 16'b11_11_11_11_11_11_11_11, 1'b0);
        // All ones with feedback stuck low.
        run(8'hFF, 16'b10_00_00_00_00_00_00_00, 16'b11_00_00_00_00_00_00_00, 1'b1);

        // start held for 30 edges: runs begin at edges 0, 11 and 22 only.
        for (int k = 0; k < 3; k++)
            push(8'hFF, 16'b10_00_00_00_00_00_00_00, 16'b11_00_00_00_00_00_00_00, 1'b1);
        seq_in = 8'hFF;
        force0 = 1'b1;
        start  = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        force0 = 1'b0;

        // Abort with reset while idx is 3.
        seq_in = 8'hFF;
        force0 = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_pre_busy",  32'(busy_v), 32'd3);
        chk("abort_pre_exp_q", 32'(expq_v), 32'd3);
        chk("abort_pre_err0",  32'(err0), CHK ? 32'd1 : 32'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_idle("abort");
        @(posedge clk);
        #1;
        reset  = 1'b0;
        force0 = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        run(8'hB2, 16'b00_10_01_00_10_00_01_10, 16'b00_11_11_00_11_00_11_11, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_left0", 32'(sbq0.size()), 32'd0);
        chk("sb_left1", 32'(sbq1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
